// File: rtl/apb4_rcu_seq.sv
// APB4 clock-gate / reset sequencer for NCH peripheral channels.
// One shared sequencer: gate -> assert reset -> hold -> ungate -> release.
`timescale 1ns/1ps
module apb4_rcu_seq #(
    parameter int NCH = 8,
    parameter int DLY_W = 8,
    parameter int DLY_DEF = 15,
    parameter int GATE_CYC = 2,
    parameter logic [NCH-1:0] CLKEN_RST = '1
) (
    input  logic           pclk,
    input  logic           presetn,
    input  logic [31:0]    paddr,
    input  logic           psel,
    input  logic           penable,
    input  logic           pwrite,
    input  logic [31:0]    pwdata,
    output logic [31:0]    prdata,
    output logic           pready,
    output logic           pslverr,
    input  logic [NCH-1:0] rst_req_i,
    output logic [NCH-1:0] clk_en_o,
    output logic [NCH-1:0] rst_n_o,
    output logic           irq_o
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int GW = $clog2(GATE_CYC + 1);
    localparam int CW = (DLY_W > GW) ? DLY_W : GW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATE,
        S_ASSERT,
        S_UNGATE,
        S_RELEASE
    } state_t;

    state_t         st, st_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [CHW-1:0] cur, cur_nxt;
    logic [CHW-1:0] ptr, ptr_nxt;
    logic [CHW-1:0] gnt_idx;
    logic [CHW:0]   arb_j;
    logic           gnt_vld;

    logic [NCH-1:0]   clken, pend, done, ie;
    logic [DLY_W-1:0] dly;
    logic [NCH-1:0]   gnt_mask, done_set, cur_oh, wmask;
    logic [3:0]       idx;
    logic             acc, wr, rd, busy, gated;
    logic [31:0]      stat;
    logic             unused_bits;

    assign idx   = paddr[5:2];
    assign acc   = psel & penable;
    assign wr    = acc & pwrite;
    assign rd    = acc & ~pwrite;
    assign wmask = pwdata[NCH-1:0];
    assign busy  = (st != S_IDLE);
    assign gated = (st == S_GATE) || (st == S_ASSERT);

    assign pready  = 1'b1;
    assign pslverr = acc && (idx > 4'd5);

    assign unused_bits = ^{paddr[31:6], paddr[1:0], pwdata};

    // Round-robin: first pending channel at or after ptr, wrapping.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        arb_j   = '0;
        for (int k = 0; k < NCH; k++) begin
            arb_j = {1'b0, ptr} + (CHW+1)'(k);
            if (arb_j >= (CHW+1)'(NCH))
                arb_j = arb_j - (CHW+1)'(NCH);
            if (!gnt_vld && pend[arb_j[CHW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = arb_j[CHW-1:0];
            end
        end
    end

    always_comb begin
        cur_oh      = '0;
        cur_oh[cur] = 1'b1;
    end

    always_comb begin
        st_nxt   = st;
        cnt_nxt  = cnt;
        cur_nxt  = cur;
        ptr_nxt  = ptr;
        gnt_mask = '0;
        done_set = '0;
        unique case (st)
            S_IDLE: begin
                if (gnt_vld) begin
                    gnt_mask[gnt_idx] = 1'b1;
                    cur_nxt = gnt_idx;
                    if (gnt_idx == CHW'(NCH - 1))
                        ptr_nxt = '0;
                    else
                        ptr_nxt = gnt_idx + CHW'(1);
                    cnt_nxt = CW'(GATE_CYC - 1);
                    st_nxt  = S_GATE;
                end
            end
            S_GATE: begin
                if (cnt == '0) begin
                    cnt_nxt = CW'(dly);
                    st_nxt  = S_ASSERT;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_ASSERT: begin
                if (cnt == '0) begin
                    cnt_nxt = CW'(GATE_CYC - 1);
                    st_nxt  = S_UNGATE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_UNGATE: begin
                if (cnt == '0)
                    st_nxt = S_RELEASE;
                else
                    cnt_nxt = cnt - CW'(1);
            end
            S_RELEASE: begin
                done_set = cur_oh;
                st_nxt   = S_IDLE;
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            st       <= S_IDLE;
            cnt      <= '0;
            cur      <= '0;
            ptr      <= '0;
            clken    <= CLKEN_RST;
            pend     <= '1;
            done     <= '0;
            ie       <= '0;
            dly      <= DLY_W'(DLY_DEF);
            clk_en_o <= '0;
            rst_n_o  <= '0;
            irq_o    <= 1'b0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
            cur <= cur_nxt;
            ptr <= ptr_nxt;
            if (wr && idx == 4'd0)
                clken <= wmask;
            pend <= (pend & ~gnt_mask) | rst_req_i
                  | ((wr && idx == 4'd1) ? wmask : '0);
            if (wr && idx == 4'd3)
                dly <= pwdata[DLY_W-1:0];
            // Set beats a same-cycle W1C.
            done <= (done & ~((wr && idx == 4'd4) ? wmask : '0))
                  | done_set;
            if (wr && idx == 4'd5)
                ie <= wmask;
            clk_en_o <= clken & ~(gated ? cur_oh : '0);
            rst_n_o  <= (rst_n_o & ~((st == S_ASSERT) ? cur_oh : '0))
                      | ((st == S_RELEASE) ? cur_oh : '0);
            irq_o    <= |(done & ie);
        end
    end

    always_comb begin
        stat        = 32'(pend);
        stat[20:16] = 5'(cur);
        stat[31]    = busy;
    end

    always_comb begin
        prdata = '0;
        if (rd) begin
            unique case (idx)
                4'd0:    prdata = 32'(clken);
                4'd1:    prdata = 32'(pend);
                4'd2:    prdata = stat;
                4'd3:    prdata = 32'(dly);
                4'd4:    prdata = 32'(done);
                4'd5:    prdata = 32'(ie);
                default: prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_rcu_seq.sv
// Bench for apb4_rcu_seq: time-based reference model feeds a scoreboard
// that is drained on every observed channel reset release.
`timescale 1ns/1ps
module tb_apb4_rcu_seq;

    localparam int NCH = 8;
    localparam int DLY_W = 8;
    localparam int DLY_DEF = 15;
    localparam int G = 2;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic [31:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  rst_req_i = '0;
    logic [7:0]  clk_en_o;
    logic [7:0]  rst_n_o;
    logic        irq_o;

    apb4_rcu_seq #(
        .NCH(NCH), .DLY_W(DLY_W), .DLY_DEF(DLY_DEF),
        .GATE_CYC(G), .CLKEN_RST(8'hFF)
    ) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .rst_req_i(rst_req_i),
        .clk_en_o(clk_en_o), .rst_n_o(rst_n_o), .irq_o(irq_o)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int ch;
        int e;
        int dly;
        bit clk_on;
        bit was_high;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: channel timeline derived from hold/gate lengths.
    int       edge_n = 0;
    logic [7:0] pend_m, done_m, ie_m, clken_m, rst_m;
    int       dly_m, ptr_m, cur_m, cur_e, rel_edge, free_edge;
    bit       rec_pend, irq_m;
    rec_t     cur_rec;

    function automatic int rr_pick(input logic [7:0] p, input int start);
        int c;
        for (int k = 0; k < NCH; k++) begin
            c = (start + k) % NCH;
            if (p[c[2:0]]) return c;
        end
        return -1;
    endfunction

    always @(posedge pclk) begin
        logic [7:0] pend_o, done_o, ie_o, clken_o, gbit, dset, wd;
        int dly_o, g, widx;
        bit w;
        edge_n++;
        if (!presetn) begin
            pend_m = '1; done_m = '0; ie_m = '0; clken_m = '1;
            rst_m = '0; dly_m = DLY_DEF; ptr_m = 0; cur_m = 0;
            rel_edge = -1; free_edge = edge_n; rec_pend = 0;
            irq_m = 0;
            q.delete();
        end else begin
            w = psel && penable && pwrite;
            widx = int'(paddr[5:2]);
            wd = pwdata[7:0];
            pend_o = pend_m; done_o = done_m; ie_o = ie_m;
            clken_o = clken_m; dly_o = dly_m;
            irq_m = |(done_o & ie_o);
            dset = '0;
            if (edge_n == rel_edge) dset[cur_m[2:0]] = 1'b1;
            if (rec_pend && edge_n == cur_e + G) begin
                cur_rec.dly = dly_o;
                rel_edge = cur_e + 2 * G + dly_o + 2;
                free_edge = rel_edge + 1;
                q.push_back(cur_rec);
                rec_pend = 0;
            end
            gbit = '0;
            if (edge_n >= free_edge && pend_o != 0) begin
                g = rr_pick(pend_o, ptr_m);
                gbit[g[2:0]] = 1'b1;
                ptr_m = (g + 1) % NCH;
                cur_m = g;
                cur_e = edge_n;
                free_edge = 1 << 30;
                cur_rec.ch = g;
                cur_rec.e = edge_n;
                cur_rec.dly = 0;
                cur_rec.clk_on = clken_o[g[2:0]];
                cur_rec.was_high = rst_m[g[2:0]];
                rst_m[g[2:0]] = 1'b1;
                rec_pend = 1;
            end
            pend_m = (pend_o & ~gbit) | rst_req_i
                   | ((w && widx == 1) ? wd : 8'h00);
            done_m = (done_o & ~((w && widx == 4) ? wd : 8'h00)) | dset;
            if (w && widx == 0) clken_m = wd;
            if (w && widx == 3) dly_m = int'(wd);
            if (w && widx == 5) ie_m = wd;
        end
    end

    function automatic logic [31:0] exp_reg(input int ix);
        logic [31:0] s;
        case (ix)
            0: s = {24'b0, clken_m};
            1: s = {24'b0, pend_m};
            2: begin
                s = {24'b0, pend_m};
                s[20:16] = 5'(cur_m);
                s[31] = (edge_n + 2 <= free_edge);
            end
            3: s = 32'(dly_m);
            4: s = {24'b0, done_m};
            5: s = {24'b0, ie_m};
            default: s = '0;
        endcase
        return s;
    endfunction

    // Monitor: every rst_n_o rising edge retires one scoreboard entry.
    initial begin
        logic [7:0] pc, pr;
        int cf[NCH], cr[NCH], rf[NCH];
        rec_t r;
        pc = '0; pr = '0;
        forever begin
            @(posedge pclk);
            #1;
            if (!presetn) begin
                pc = clk_en_o; pr = rst_n_o;
                for (int i = 0; i < NCH; i++) begin
                    cf[i] = -1; cr[i] = -1; rf[i] = -1;
                end
            end else begin
                chk("irq", 32'(irq_o), 32'(irq_m));
                for (int i = 0; i < NCH; i++) begin
                    if (pc[i] && !clk_en_o[i]) cf[i] = edge_n;
                    if (!pc[i] && clk_en_o[i]) cr[i] = edge_n;
                    if (pr[i] && !rst_n_o[i]) rf[i] = edge_n;
                    if (!pr[i] && rst_n_o[i]) begin
                        if (q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_release ch=%0d actual=rise required=none", i);
                        end else begin
                            r = q.pop_front();
                            chk("release_ch", 32'(i), 32'(r.ch));
                            chk("release_time", 32'(edge_n),
                                32'(r.e + 2 * G + r.dly + 2));
                            if (r.clk_on) begin
                                chk("gate_time", 32'(cf[i]), 32'(r.e + 1));
                                chk("ungate_time", 32'(cr[i]),
                                    32'(r.e + G + r.dly + 2));
                            end else begin
                                chk("clk_stays_off", 32'(clk_en_o[i]), 32'd0);
                            end
                            if (r.was_high)
                                chk("rst_assert_time", 32'(rf[i]),
                                    32'(r.e + G + 1));
                        end
                    end
                end
                pc = clk_en_o; pr = rst_n_o;
            end
        end
    end

    task automatic apb_wr(input int ix, input logic [31:0] d);
        @(negedge pclk);
        paddr = 32'(ix) << 2; pwdata = d; pwrite = 1'b1;
        psel = 1'b1; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input int ix);
        @(negedge pclk);
        paddr = 32'(ix) << 2; pwrite = 1'b0;
        psel = 1'b1; penable = 1'b0;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        chk($sformatf("rd%0d_data", ix), prdata, exp_reg(ix));
        chk($sformatf("rd%0d_err", ix), 32'(pslverr), 32'(ix > 5));
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((q.size() != 0 || pend_m != 0 || edge_n + 2 <= free_edge)
               && n < 3000) begin
            @(negedge pclk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL %s actual=busy required=idle", nm);
        end
    endtask

    initial begin
        int op;
        repeat (3) @(negedge pclk);
        chk("rst_clk_en", 32'(clk_en_o), 32'h00);
        chk("rst_rst_n", 32'(rst_n_o), 32'h00);
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("pready", 32'(pready), 32'h1);
        for (int i = 0; i < 6; i++) apb_rd(i);
        apb_rd(7);

        @(negedge pclk);
        presetn = 1'b1;
        wait_idle("boot");
        chk("boot_rst_n", 32'(rst_n_o), 32'hFF);
        apb_rd(4);

        apb_wr(5, 32'h01);
        repeat (3) @(negedge pclk);
        chk("irq_on", 32'(irq_o), 32'h1);
        apb_wr(4, 32'h01);
        repeat (3) @(negedge pclk);
        chk("irq_off", 32'(irq_o), 32'h0);
        apb_rd(4);
        apb_rd(7);

        apb_wr(1, 32'h24);
        wait_idle("req_24");

        apb_wr(1, 32'h02);
        repeat (4) @(negedge pclk);
        rst_req_i = 8'h08;
        @(negedge pclk);
        rst_req_i = 8'h00;
        apb_rd(2);
        apb_rd(1);
        wait_idle("hw_pulse");

        apb_wr(0, 32'h00);
        @(negedge pclk);
        chk("clken_follow", 32'(clk_en_o), 32'h00);
        apb_wr(1, 32'h01);
        wait_idle("clken_off");
        apb_wr(0, 32'hFF);

        apb_wr(3, 32'h03);
        apb_wr(1, 32'h80);
        wait_idle("dly3");
        apb_wr(3, 32'h00);
        apb_wr(1, 32'h40);
        wait_idle("dly0");

        apb_wr(3, 32'h0A);
        apb_wr(1, 32'h80);
        repeat (5) @(negedge pclk);
        apb_wr(3, 32'h02);
        wait_idle("dly_mid_assert");

        rst_req_i = 8'h40;
        apb_wr(1, 32'h11);
        repeat (100) @(negedge pclk);
        apb_rd(2);
        rst_req_i = 8'h00;
        wait_idle("held_req");

        apb_wr(4, 32'hFF);
        for (int it = 0; it < 40; it++) begin
            op = int'($urandom_range(0, 7));
            case (op)
                0: apb_wr(1, 32'($urandom_range(0, 255)));
                1: begin
                    rst_req_i = 8'($urandom_range(0, 255));
                    repeat ($urandom_range(1, 3)) @(negedge pclk);
                    rst_req_i = 8'h00;
                end
                2: apb_rd(2);
                3: apb_wr(4, 32'($urandom_range(0, 255)));
                4: apb_wr(5, 32'($urandom_range(0, 255)));
                5: apb_wr(3, 32'($urandom_range(0, 6)));
                6: repeat ($urandom_range(0, 30)) @(negedge pclk);
                default: begin
                    apb_rd(4);
                    apb_rd(int'($urandom_range(6, 15)));
                end
            endcase
        end
        wait_idle("random");
        apb_rd(4);

        apb_wr(3, 32'h0F);
        apb_wr(1, 32'h10);
        repeat (8) @(negedge pclk);
        presetn = 1'b0;
        #1;
        chk("midrst_clk_en", 32'(clk_en_o), 32'h00);
        chk("midrst_rst_n", 32'(rst_n_o), 32'h00);
        chk("midrst_irq", 32'(irq_o), 32'h0);
        repeat (2) @(negedge pclk);
        apb_rd(2);
        apb_rd(3);
        @(negedge pclk);
        presetn = 1'b1;
        wait_idle("reboot");
        chk("reboot_rst_n", 32'(rst_n_o), 32'hFF);
        apb_rd(4);
        chk("sb_drain", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
